// File: rtl/block_packer_if.sv
// Valid/ready stream bundle shared by the byte-side and block-side
// ports of block_packer; W sets the data width.
interface block_packer_if #(
   parameter int W = 8
) ();

   logic [W-1:0] tdata;
   logic         tvalid;
   logic         tlast;
   logic         tready;

   modport master (
      output tdata,
      output tvalid,
      output tlast,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      input  tlast,
      output tready
   );

endinterface

// File: rtl/block_packer.sv
// Byte-to-64-bit block packer with PKCS#7 or zero end-of-message padding,
// one registered output block with valid/ready backpressure.
module block_packer #(
   parameter int PKCS7 = 1
) (
   input  logic          clk,
   input  logic          rst,
   block_packer_if.slave  s_axis,
   block_packer_if.master m_axis,
   output logic [31:0]   block_count
);

   typedef enum logic {
      FILL = 1'b0,
      PAD  = 1'b1
   } state_e;

   localparam bit          USE_PKCS7 = (PKCS7 != 0);
   localparam logic [63:0] PAD_BLK   = {8{8'h08}};

   state_e      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [55:0] acc_q, acc_d;
   logic [63:0] data_q, data_d;
   logic        valid_q, valid_d;
   logic        last_q, last_d;
   logic [31:0] cnt_q, cnt_d;

   logic        out_free;
   logic        s_rdy;
   logic        byte_hs;
   logic        full;
   logic        complete;
   logic        fill_hs;
   logic        pad_ld;
   logic        accept;
   logic [7:0]  pad_byte;
   logic [63:0] acc_ext;
   logic [63:0] blk;
   logic [55:0] acc_wr;

   assign out_free = !valid_q || m_axis.tready;
   assign s_rdy    = rst && (state_q == FILL) && out_free;
   assign byte_hs  = s_axis.tvalid && s_rdy;
   assign full     = (idx_q == 3'd7);
   assign complete = byte_hs && (full || s_axis.tlast);
   assign fill_hs  = byte_hs && !complete;
   assign pad_ld   = (state_q == PAD) && out_free;
   assign accept   = valid_q && m_axis.tready;
   assign acc_ext  = {acc_q, 8'h00};

   // Pad value is the count of missing bytes (8-k), i.e. 7-idx.
   assign pad_byte = USE_PKCS7 ? {5'd0, 3'(3'd7 - idx_q)} : 8'h00;

   // Merge stored bytes, the incoming byte and padding into one block,
   // and form the accumulator image with the incoming byte written in.
   always_comb begin
      blk    = '0;
      acc_wr = acc_q;
      for (int i = 0; i < 8; i++) begin
         if (i < int'(idx_q)) begin
            blk[63-8*i -: 8] = acc_ext[63-8*i -: 8];
         end else if (i == int'(idx_q)) begin
            blk[63-8*i -: 8] = s_axis.tdata;
         end else begin
            blk[63-8*i -: 8] = pad_byte;
         end
      end
      for (int i = 0; i < 7; i++) begin
         if (i == int'(idx_q)) begin
            acc_wr[55-8*i -: 8] = s_axis.tdata;
         end
      end
   end

   // Next-state for the FILL/PAD sequencer and the output block register;
   // a load in the same cycle as an accept keeps tvalid high.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      if (accept) begin
         valid_d = 1'b0;
      end
      unique case (1'b1)
         complete: begin
            idx_d   = '0;
            data_d  = blk;
            valid_d = 1'b1;
            last_d  = s_axis.tlast && !(USE_PKCS7 && full);
            if (USE_PKCS7 && full && s_axis.tlast) begin
               state_d = PAD;
            end
         end
         fill_hs: begin
            acc_d = acc_wr;
            idx_d = idx_q + 3'd1;
         end
         pad_ld: begin
            data_d  = PAD_BLK;
            valid_d = 1'b1;
            last_d  = 1'b1;
            state_d = FILL;
         end
         default: ;
      endcase
   end

   // Sequencer and output register state; reset drops any partial block
   // and any pending pad block.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FILL;
         idx_q   <= '0;
         acc_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   assign cnt_d = cnt_q + {31'd0, accept};

   // Debug count of blocks taken downstream, wrapping at 2^32.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign s_axis.tready = s_rdy;
   assign m_axis.tdata  = data_q;
   assign m_axis.tvalid = valid_q;
   assign m_axis.tlast  = last_q;
   assign block_count   = cnt_q;

endmodule

// File: doc/block_packer.md
# block_packer

Upstream AXI-Stream byte-to-block packer for the MacGuffin datapath. Accepts a byte-wide message stream with `tlast` framing, assembles 64-bit blocks (first byte in the most-significant byte), applies end-of-message padding and presents each block to the encryption pipeline's 64-bit slave stream. It holds one output block register with standard valid/ready backpressure, plus a running block counter for debug.

## Interface
Parameters:
- `PKCS7`, default 1: 1 selects PKCS#7 padding; 0 selects zero padding with no extra block.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `s_axis_tdata`  in  8  message byte.
- `s_axis_tvalid`  in  1  byte valid.
- `s_axis_tlast`  in  1  marks the final byte of a message.
- `s_axis_tready`  out  1  packer can accept a byte this cycle.
- `m_axis_tdata`  out  64  assembled block; byte 0 of the block is in [63:56].
- `m_axis_tvalid`  out  1  block valid.
- `m_axis_tlast`  out  1  block is the last block of its message.
- `m_axis_tready`  in  1  consumer (encryption stage `s_axis_tready`) accepts the block.
- `block_count`  out  32  number of blocks accepted downstream since reset; wraps modulo 2^32.

## Operation
- Internal state:
  - 56-bit byte accumulator `acc`.
  - 3-bit byte index `idx` (0..7).
  - FSM with states FILL and PAD.
- `out_free = !m_axis_tvalid || m_axis_tready`.
- `s_axis_tready = (state == FILL) && out_free`. It is forced to 0 while `rst` is low.
- Byte handshake in FILL:
  - If the byte is not completing (`idx < 7` and `!tlast`), store it at byte position `idx` and increment `idx`.
  - A byte is completing when `idx == 7` or `tlast == 1`. A completing byte loads the output register in the same edge with accumulator bytes 0..idx-1, the new byte at position `idx`, and padding in positions idx+1..7.
  - After a completing byte, `idx` returns to 0.
- Padding, with k = idx+1 bytes of data in the final block:
  - PKCS7=1, k<8: pad bytes equal 8-k.
  - PKCS7=1, k==8 with tlast: emit the data block with `m_axis_tlast=0` and enter PAD.
  - PKCS7=0: pad bytes are 0x00. A full block with tlast gets `m_axis_tlast=1` and there is no PAD state.
  - A full block without tlast has `m_axis_tlast=0`.
- PAD state: `s_axis_tready=0`. When `out_free`, load 0x0808080808080808 with `m_axis_tlast=1` and return to FILL.
- Output register:
  - Loads on any load event.
  - Clears `m_axis_tvalid` on (`m_axis_tvalid && m_axis_tready`) with no simultaneous load.
  - Simultaneous accept and load: the new block replaces the old one and `m_axis_tvalid` stays 1 (zero bubble).
- `block_count` increments on each `m_axis_tvalid && m_axis_tready` cycle.

## Timing
- Reset values (rst low, asynchronous):
  - State FILL, `idx=0`, `acc=0`.
  - `m_axis_tdata=0`, `m_axis_tvalid=0`, `m_axis_tlast=0`, `block_count=0`, `s_axis_tready=0`.
- Latency: `m_axis_tvalid` rises the cycle after the completing-byte handshake edge.
- Throughput: 8 bytes per block, one byte per cycle sustained while `m_axis_tready=1`.
- The extra PKCS#7 block appears on the cycle after the full data block is accepted. If the data block is accepted on its first valid cycle, the extra block follows back-to-back.
- Backpressure: while `m_axis_tvalid=1` and `m_axis_tready=0`, the output holds `tdata`/`tlast` stable and `s_axis_tready=0`. No byte is lost or duplicated.
- `s_axis_tready` depends combinationally on `m_axis_tready`. This is permitted because the downstream `s_axis_tready` is registered-derived.
- Reset mid-block: a partially accumulated block is discarded, a pending PAD is cancelled, and the next byte after reset release starts a new block at index 0.
- tlast on the first byte of a block (k=1) is legal. An empty message (tlast with no data) cannot occur, since tlast is always attached to a byte.

## Test plan
- Bytes 01 02 03 with tlast on 03, `m_axis_tready=1`, PKCS7=1 -> one block 0x0102030505050505 with `m_axis_tlast=1`, valid 1 cycle after the 03 handshake; `block_count=1`.
- Bytes 01..08 with tlast on 08, PKCS7=1 -> 0x0102030405060708 (`tlast=0`), then 0x0808080808080808 (`tlast=1`) on the next cycle; `s_axis_tready=0` during PAD; `block_count=2`.
- 16 bytes 00..0F without tlast, `m_axis_tready` held 0 for 5 cycles after the first block -> `s_axis_tready=0` and `m_axis_tdata=0x0001020304050607` stable for those cycles, then 0x08090A0B0C0D0E0F; no bytes dropped.
- PKCS7=0, bytes AA BB with tlast -> 0xAABB000000000000 with `tlast=1`. 8 bytes with tlast -> a single block with `tlast=1` and no extra block.
- Reset asserted after 5 bytes of a block, then bytes 11..18 with tlast -> all outputs 0 during reset; the next output is 0x1112131415161718 followed by the 0x08 pad block.
- Continuous stream with `m_axis_tready=1` -> blocks emitted every 8 cycles with no bubbles; `block_count` wraps from 0xFFFFFFFF to 0 (preload via force).
